// File: rtl/sram_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_fifo: single-clock FIFO, registered read port, count-derived flags. |
// | Optional sticky error flags: define SRAM_FIFO_ERR_FLAGS_EN.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sram_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf_err,
  output logic                  udf_err
);

  localparam int                 c_depth      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_depth_cnt = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] c_afull_cnt = (ADDR_WIDTH+1)'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // Flags come straight from the count register, so they never lag it.
  assign full        = (r_count == c_depth_cnt);
  assign empty       = (r_count == '0);
  assign almost_full = (r_count >= c_afull_cnt);
  assign count       = r_count;
  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;

  assign w_wr_acc = wr_en & ~full;
  assign w_rd_acc = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + (ADDR_WIDTH+1)'(w_wr_acc) - (ADDR_WIDTH+1)'(w_rd_acc);
    end
  end

`ifdef SRAM_FIFO_ERR_FLAGS_EN
  logic r_ovf_err;
  logic r_udf_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      r_ovf_err <= r_ovf_err | (wr_en & full);
      r_udf_err <= r_udf_err | (rd_en & empty);
    end
  end

  assign ovf_err = r_ovf_err;
  assign udf_err = r_udf_err;
`else
  assign ovf_err = 1'b0;
  assign udf_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_fifo: directed + random stimulus against a queue-based model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sram_fifo;

  localparam int c_dw    = 16;
  localparam int c_aw    = 3;
  localparam int c_depth = 8;
  localparam int c_afull = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [c_dw-1:0] data_in = '0;
  logic            rd_en = 1'b0;
  logic [c_dw-1:0] data_out;
  logic            data_valid;
  logic            full;
  logic            empty;
  logic            almost_full;
  logic [c_aw:0]   count;
  logic            ovf_err;
  logic            udf_err;

  int errors = 0;
  int checks = 0;

`ifdef SRAM_FIFO_ERR_FLAGS_EN
  localparam logic c_flags_on = 1'b1;
`else
  localparam logic c_flags_on = 1'b0;
`endif

  sram_fifo #(
    .DATA_WIDTH  (c_dw),
    .ADDR_WIDTH  (c_aw),
    .AFULL_THRESH(c_afull)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full),
    .count      (count),
    .ovf_err    (ovf_err),
    .udf_err    (udf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of stored words plus last-popped word.
  logic [c_dw-1:0] m_q[$];
  logic [c_dw-1:0] m_dout;
  logic            m_valid;
  logic            m_ovf;
  logic            m_udf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      automatic int  n   = m_q.size();
      automatic bit  wac = wr_en && (n < c_depth);
      automatic bit  rac = rd_en && (n > 0);
      if (wr_en && n == c_depth) m_ovf = c_flags_on;
      if (rd_en && n == 0)       m_udf = c_flags_on;
      m_valid = rac;
      if (rac) m_dout = m_q.pop_front();
      if (wac) m_q.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_count",  32'(count),       32'(m_q.size()));
      chk("m_full",   32'(full),        32'(m_q.size() == c_depth));
      chk("m_empty",  32'(empty),       32'(m_q.size() == 0));
      chk("m_afull",  32'(almost_full), 32'(m_q.size() >= c_afull));
      chk("m_valid",  32'(data_valid),  32'(m_valid));
      chk("m_dout",   32'(data_out),    32'(m_dout));
      chk("m_ovf",    32'(ovf_err),     32'(m_ovf));
      chk("m_udf",    32'(udf_err),     32'(m_udf));
    end
  end

  // Called just after a rising edge; applies inputs for the next edge.
  task automatic step(input logic w, input logic [c_dw-1:0] d, input logic r);
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * c_depth && m_q.size() > 0; k++) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full), 0);
    chk("rst_dout",  32'(data_out), 0);
    rst_n = 1'b1;

    // Fill 1..8; almost_full rises on the 6th write.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, c_dw'(i), 1'b0);
      chk("first_wr_count", 32'(count), 32'(i));
      if (i == 5) chk("afull_at5", 32'(almost_full), 0);
      if (i == 6) chk("afull_at6", 32'(almost_full), 1);
    end
    chk("fill_full", 32'(full), 1);

    step(1'b1, 16'hDEAD, 1'b0);
    chk("ovf_set", 32'(ovf_err), 32'(c_flags_on));
    chk("ovf_count", 32'(count), 8);

    for (int i = 1; i <= 8; i++) begin
      step(1'b0, '0, 1'b1);
      chk("rd_valid", 32'(data_valid), 1);
      chk("rd_data",  32'(data_out), 32'(i));
    end
    chk("drained_empty", 32'(empty), 1);
    step(1'b0, '0, 1'b0);
    chk("valid_drop", 32'(data_valid), 0);
    chk("dout_hold",  32'(data_out), 8);

    step(1'b0, '0, 1'b1);
    chk("udf_set",     32'(udf_err), 32'(c_flags_on));
    chk("udf_novalid", 32'(data_valid), 0);
    chk("ovf_persist", 32'(ovf_err), 32'(c_flags_on));

    // Preload 3, then stream 20 words with both enables high.
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0100 + c_dw'(i), 1'b0);
    for (int i = 3; i < 23; i++) begin
      step(1'b1, 16'h0100 + c_dw'(i), 1'b1);
      chk("stream_count", 32'(count), 3);
      chk("stream_data",  32'(data_out), 32'(16'h0100 + i - 3));
    end
    drain();

    // Full + both high: read wins, 0xBEEF dropped.
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0200 + c_dw'(i), 1'b0);
    step(1'b1, 16'hBEEF, 1'b1);
    chk("full_both_count", 32'(count), 7);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, '0, 1'b1);
      chk("no_beef", 32'(data_out == 16'hBEEF), 0);
    end
    step(1'b1, 16'h0AAA, 1'b1);
    chk("empty_both_count", 32'(count), 1);
    chk("empty_both_valid", 32'(data_valid), 0);
    drain();

    // Random traffic checked by the model on every cycle.
    for (int i = 0; i < 400; i++) begin
      automatic logic w = ($urandom_range(0, 99) < 55);
      automatic logic r = ($urandom_range(0, 99) < 45);
      step(w, c_dw'($urandom), r);
    end
    drain();
    chk("flags_sticky_ovf", 32'(ovf_err), 32'(c_flags_on));
    chk("flags_sticky_udf", 32'(udf_err), 32'(c_flags_on));

    // Asynchronous reset mid-cycle with 5 words stored.
    for (int i = 0; i < 5; i++) step(1'b1, 16'h0300 + c_dw'(i), 1'b0);
    chk("pre_arst_count", 32'(count), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_afull", 32'(almost_full), 0);
    chk("arst_full",  32'(full), 0);
    chk("arst_valid", 32'(data_valid), 0);
    chk("arst_dout",  32'(data_out), 0);
    chk("arst_ovf",   32'(ovf_err), 0);
    chk("arst_udf",   32'(udf_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h4321, 1'b0);
    chk("post_rst_wr", 32'(count), 1);
    step(1'b0, '0, 1'b1);
    chk("post_rst_rd", 32'(data_out), 32'h4321);
    step(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
